// File: rtl/qos_egress_drain.sv
// Weighted round-robin drain of four egress FIFOs onto one registered valid/ready stream.
// States: ARB = idle, nothing held or in flight; WAIT = pop in flight, data arrives; HOLD = word presented.
module qos_egress_drain #(
  parameter int DATA_W   = 12,
  parameter int WEIGHT_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          empty,
  input  logic [DATA_W-1:0]   fifo_dataout0,
  input  logic [DATA_W-1:0]   fifo_dataout1,
  input  logic [DATA_W-1:0]   fifo_dataout2,
  input  logic [DATA_W-1:0]   fifo_dataout3,
  input  logic [WEIGHT_W-1:0] weight0,
  input  logic [WEIGHT_W-1:0] weight1,
  input  logic [WEIGHT_W-1:0] weight2,
  input  logic [WEIGHT_W-1:0] weight3,
  output logic [3:0]          pop,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_port,
  output logic [7:0]          word_count,
  output logic                busy
);

  typedef enum logic [1:0] {ARB, WAIT, HOLD} state_t;

  state_t              state, state_nxt;
  logic [1:0]          ptr, sel, grant_port;
  logic [WEIGHT_W-1:0] used;
  logic [WEIGHT_W-1:0] weight [4];
  logic [DATA_W-1:0]   data [4];
  logic [3:0]          eligible;
  logic                grant_valid, grant_stay, evaluate, do_grant;

  assign weight[0] = weight0;
  assign weight[1] = weight1;
  assign weight[2] = weight2;
  assign weight[3] = weight3;
  assign data[0]   = fifo_dataout0;
  assign data[1]   = fifo_dataout1;
  assign data[2]   = fifo_dataout2;
  assign data[3]   = fifo_dataout3;

  always_comb begin
    for (int i = 0; i < 4; i++) eligible[i] = !empty[i] && (weight[i] != '0);
  end

  // The search wraps back to ptr itself last, so a lone eligible port whose
  // quota is spent restarts its quota instead of starving.
  always_comb begin
    logic [1:0] cand;
    grant_valid = 1'b0;
    grant_stay  = 1'b0;
    grant_port  = ptr;
    cand        = ptr;
    if (eligible[ptr] && (used < weight[ptr])) begin
      grant_valid = 1'b1;
      grant_stay  = 1'b1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        cand = ptr + 2'(k);
        if (!grant_valid && eligible[cand]) begin
          grant_valid = 1'b1;
          grant_port  = cand;
        end
      end
    end
  end

  assign evaluate = (state == ARB) || ((state == HOLD) && out_ready);
  assign do_grant = reset && evaluate && grant_valid;
  assign busy     = (state != ARB);

  always_ff @(posedge clk) begin
    if (!reset) state <= ARB;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 4'b0000;
    if (do_grant) pop[grant_port] = 1'b1;
    case (state)
      ARB:     if (do_grant) state_nxt = WAIT;
      WAIT:    state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = do_grant ? WAIT : ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr        <= '0;
      used       <= '0;
      sel        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_port   <= '0;
      word_count <= '0;
    end else begin
      if (do_grant) begin
        sel  <= grant_port;
        ptr  <= grant_port;
        used <= grant_stay ? used + 1'b1 : WEIGHT_W'(1);
      end
      if (state == WAIT) begin
        out_data  <= data[sel];
        out_port  <= sel;
        out_valid <= 1'b1;
      end else if ((state == HOLD) && out_ready) begin
        out_valid  <= 1'b0;
        word_count <= word_count + 8'd1;
      end
    end
  end

endmodule
